// File: rtl/seq_muladd_4bit_pkg.sv
// seq_muladd_4bit_pkg: shared arithmetic-unit width, FSM states and product type
package seq_muladd_4bit_pkg;
  localparam int AU_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} au_state_t;
  typedef logic [2*AU_WIDTH-1:0] au_product_t;
endpackage

// File: rtl/seq_muladd_4bit_if.sv
// seq_muladd_4bit_if: start/busy/done handshake and operand/result bus of the multiply-accumulate
interface seq_muladd_4bit_if #(parameter int WIDTH = 4);
  logic start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] addend;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, multiplicand, multiplier, addend, input busy, done, product);
  modport slave (input start, multiplicand, multiplier, addend, output busy, done, product);
endinterface

// File: rtl/seq_muladd_4bit_step.sv
// seq_muladd_4bit_step: one shift-and-add iteration, acc + (mcand << shift) when the multiplier bit is set
module seq_muladd_4bit_step #(
  parameter int WIDTH = 4,
  parameter int CW = 2
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               en,
  input  logic [CW-1:0]      shift,
  output logic [2*WIDTH-1:0] sum
);
  assign sum = en ? acc + ({{WIDTH{1'b0}}, mcand} << shift) : acc;
endmodule

// File: rtl/seq_muladd_4bit.sv
// seq_muladd_4bit: sequential multiplicand*multiplier + addend, one multiplier bit per clock
module seq_muladd_4bit
  import seq_muladd_4bit_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH
) (
  input logic clk,
  input logic rst_n,
  seq_muladd_4bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  au_state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic accept;
  // start is only honoured outside RUN, which makes DONE->RUN back-to-back
  assign accept = bus.start && state != RUN;
  seq_muladd_4bit_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
    .acc(acc),
    .mcand(mcand),
    .en(mplier[count]),
    .shift(count),
    .sum(acc_next)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.product <= '0;
    end else if (accept) begin
      state <= RUN;
      count <= '0;
      mcand <= bus.multiplicand;
      mplier <= bus.multiplier;
      acc <= {{WIDTH{1'b0}}, bus.addend};
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc_next;
      count <= count + 1'b1;
      if (count == LAST) begin
        state <= DONE;
        bus.product <= acc_next;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end else begin
      state <= IDLE;
      bus.done <= 1'b0;
    end
  end
endmodule
